// File: rtl/ir_pkg.sv
// Shared defaults for the instruction-register queue: control-word bit
// positions and the legacy/queue operating mode.
package ir_pkg;

    localparam int IR_LOAD_BIT  = 4;
    localparam int IR_ADV_BIT   = 6;
    localparam int IR_FLUSH_BIT = 7;

    typedef enum logic {
        IR_MODE_LEGACY = 1'b0,
        IR_MODE_QUEUE  = 1'b1
    } ir_mode_e;

endpackage

// File: rtl/ir_buf_mem.sv
// DEPTH x WIDTH register array for the instruction queue: one write port,
// one asynchronous read port, contents async-cleared on reset.
module ir_buf_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ir_queue.sv
// Instruction register between MBR and CU: a DEPTH-entry circular queue
// presenting the oldest word, or the plain load-and-hold register in legacy mode.
module ir_queue
    import ir_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MODE      = int'(IR_MODE_QUEUE),
    parameter int LOAD_BIT  = IR_LOAD_BIT,
    parameter int ADV_BIT   = IR_ADV_BIT,
    parameter int FLUSH_BIT = IR_FLUSH_BIT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                control_signal,
    input  logic [WIDTH-1:0]           from_MBR,
    output logic [WIDTH-1:0]           to_CU,
    output logic                       head_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic ld, adv, fl;
    logic unused_ctrl;

    assign ld  = control_signal[LOAD_BIT];
    assign adv = control_signal[ADV_BIT];
    assign fl  = control_signal[FLUSH_BIT];
    assign unused_ctrl = ^control_signal;

    if (MODE == int'(IR_MODE_LEGACY)) begin : g_legacy
        logic [WIDTH-1:0] data_q;
        logic             loaded_q;
        logic             unused_legacy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q   <= '0;
                loaded_q <= 1'b0;
            end else if (ld) begin
                data_q   <= from_MBR;
                loaded_q <= 1'b1;
            end
        end

        assign unused_legacy = adv ^ fl;
        assign to_CU      = data_q;
        assign head_valid = loaded_q;
        assign full       = loaded_q;
        assign count      = CW'(loaded_q);
        assign err        = 1'b0;
    end else begin : g_queue
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          err_q, err_d;
        logic          we;
        logic          is_full, is_empty;

        assign is_full  = (cnt_q == CW'(DEPTH));
        assign is_empty = (cnt_q == '0);

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            err_d    = err_q;
            we       = 1'b0;
            if (fl) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
                err_d    = 1'b0;
            end else begin
                unique case ({ld, adv})
                    2'b10: begin
                        if (is_full) begin
                            err_d = 1'b1;
                        end else begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (is_empty) begin
                            err_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            cnt_d    = cnt_q - 1'b1;
                        end
                    end
                    2'b11: begin
                        // When full, wr_ptr aliases rd_ptr: the head slot is
                        // overwritten in the same edge it is popped.
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (is_empty) begin
                            cnt_d = CW'(1);
                            err_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
                err_q    <= err_d;
            end
        end

        ir_buf_mem #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_mem (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we),
            .waddr_i (wr_ptr_q),
            .wdata_i (from_MBR),
            .raddr_i (rd_ptr_q),
            .rdata_o (to_CU)
        );

        assign head_valid = !is_empty;
        assign full       = is_full;
        assign count      = cnt_q;
        assign err        = err_q;
    end

endmodule
